// File: rtl/execution_memory_register.sv
// Execute-to-memory pipeline register with valid/ready handshake.
// A one-entry skid buffer keeps in_ready_o registered, so a memory-stage
// stall reaches the execute stage without a combinational path.
module execution_memory_register #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  mem_write_en_i,
    input  logic                  mem_read_en_i,
    input  logic                  reg_file_write_en_i,
    input  logic                  reg_file_input_ctrl_sig_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  mem_write_en_o,
    output logic                  mem_read_en_o,
    output logic                  reg_file_write_en_o,
    output logic                  reg_file_input_ctrl_sig_o,
    output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    // Safe (no side effect) control encodings.
    localparam logic NO_MEM_WRITE = 1'b0;
    localparam logic NO_MEM_READ  = 1'b0;
    localparam logic NO_REG_WRITE = 1'b0;
    localparam logic FROM_ALU     = 1'b0;

    typedef struct packed {
        logic                  mem_write;
        logic                  mem_read;
        logic                  rf_write;
        logic                  rf_src;
        logic [ADDR_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] store;
    } xm_entry_t;

    localparam xm_entry_t ENTRY_ZERO = '0;

    // Force the control fields of an entry to side-effect-free values,
    // leaving data and destination untouched.
    function automatic xm_entry_t safe_ctrl(input xm_entry_t e);
        xm_entry_t r;
        r           = e;
        r.mem_write = NO_MEM_WRITE;
        r.mem_read  = NO_MEM_READ;
        r.rf_write  = NO_REG_WRITE;
        r.rf_src    = FROM_ALU;
        return r;
    endfunction

    xm_entry_t main_r;
    xm_entry_t skid_r;
    logic      main_valid_r;
    logic      skid_valid_r;
    logic      in_ready_r;

    xm_entry_t in_entry_s;
    xm_entry_t main_next_s;
    xm_entry_t skid_next_s;
    logic      main_valid_next_s;
    logic      skid_valid_next_s;
    logic      in_fire_s;
    logic      out_fire_s;

    assign in_fire_s  = in_valid_i & in_ready_r;
    assign out_fire_s = main_valid_r & out_ready_i;

    // Next-state selection for the main/skid pair; state is {main_valid, skid_valid}.
    always_comb begin
        in_entry_s = '{mem_write: mem_write_en_i,
                       mem_read:  mem_read_en_i,
                       rf_write:  reg_file_write_en_i,
                       rf_src:    reg_file_input_ctrl_sig_i,
                       dest:      reg_dest_addr_i,
                       alu:       alu_result_i,
                       store:     store_data_i};
        main_next_s       = main_r;
        skid_next_s       = skid_r;
        main_valid_next_s = main_valid_r;
        skid_valid_next_s = skid_valid_r;
        if (flush_i) begin
            // Flush wins over a same-cycle input; an output fire needs no action.
            main_next_s       = safe_ctrl(main_r);
            main_valid_next_s = 1'b0;
            skid_valid_next_s = 1'b0;
        end else begin
            case ({main_valid_r, skid_valid_r})
                2'b00: begin
                    if (in_fire_s) begin
                        main_next_s       = in_entry_s;
                        main_valid_next_s = 1'b1;
                    end else begin
                        main_next_s = main_r;
                    end
                end
                2'b10: begin
                    if (in_fire_s && out_fire_s) begin
                        main_next_s = in_entry_s;
                    end else if (in_fire_s) begin
                        skid_next_s       = in_entry_s;
                        skid_valid_next_s = 1'b1;
                    end else if (out_fire_s) begin
                        main_next_s       = safe_ctrl(main_r);
                        main_valid_next_s = 1'b0;
                    end else begin
                        main_next_s = main_r;
                    end
                end
                2'b11: begin
                    if (out_fire_s) begin
                        main_next_s       = skid_r;
                        skid_valid_next_s = 1'b0;
                    end else begin
                        main_next_s = main_r;
                    end
                end
                default: begin
                    // Skid valid without main valid is unreachable; recover to EMPTY.
                    main_next_s       = safe_ctrl(main_r);
                    main_valid_next_s = 1'b0;
                    skid_valid_next_s = 1'b0;
                end
            endcase
        end
    end

    // State registers; in_ready is derived from the next skid occupancy.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            main_r       <= safe_ctrl(ENTRY_ZERO);
            skid_r       <= ENTRY_ZERO;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_r       <= main_next_s;
            skid_r       <= skid_next_s;
            main_valid_r <= main_valid_next_s;
            skid_valid_r <= skid_valid_next_s;
            in_ready_r   <= ~skid_valid_next_s;
        end
    end

    assign in_ready_o                = in_ready_r;
    assign out_valid_o               = main_valid_r;
    assign mem_write_en_o            = main_r.mem_write;
    assign mem_read_en_o             = main_r.mem_read;
    assign reg_file_write_en_o       = main_r.rf_write;
    assign reg_file_input_ctrl_sig_o = main_r.rf_src;
    assign reg_dest_addr_o           = main_r.dest;
    assign alu_result_o              = main_r.alu;
    assign store_data_o              = main_r.store;

endmodule

// File: tb/tb_execution_memory_register.sv
// Directed self-checking bench for execution_memory_register.
module tb_execution_memory_register;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          mem_write_en_i, mem_read_en_i, reg_file_write_en_i, reg_file_input_ctrl_sig_i;
    logic          mem_write_en_o, mem_read_en_o, reg_file_write_en_o, reg_file_input_ctrl_sig_o;
    logic [AW-1:0] reg_dest_addr_i, reg_dest_addr_o;
    logic [DW-1:0] alu_result_i, alu_result_o;
    logic [DW-1:0] store_data_i, store_data_o;
    logic          out_valid_o;
    logic          out_ready_i;

    int test_count = 0;
    int fail_count = 0;

    execution_memory_register #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mem_write_en_i(mem_write_en_i), .mem_read_en_i(mem_read_en_i),
        .reg_file_write_en_i(reg_file_write_en_i),
        .reg_file_input_ctrl_sig_i(reg_file_input_ctrl_sig_i),
        .reg_dest_addr_i(reg_dest_addr_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i),
        .mem_write_en_o(mem_write_en_o), .mem_read_en_o(mem_read_en_o),
        .reg_file_write_en_o(reg_file_write_en_o),
        .reg_file_input_ctrl_sig_o(reg_file_input_ctrl_sig_o),
        .reg_dest_addr_o(reg_dest_addr_o), .alu_result_o(alu_result_o),
        .store_data_o(store_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] alu);
        in_valid_i   = v;
        alu_result_i = alu;
    endtask

    initial begin
        reset_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        mem_write_en_i = 1'b0; mem_read_en_i = 1'b0; reg_file_write_en_i = 1'b0;
        reg_file_input_ctrl_sig_i = 1'b0; reg_dest_addr_i = 5'd0;
        alu_result_i = 32'd0; store_data_i = 32'd0;

        // Reset state
        #12;
        check_value("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_value("rst_in_ready", 64'(in_ready_o), 64'd1);
        check_value("rst_mem_write", 64'(mem_write_en_o), 64'd0);
        check_value("rst_alu", 64'(alu_result_o), 64'd0);
        check_value("rst_store", 64'(store_data_o), 64'd0);
        check_value("rst_dest", 64'(reg_dest_addr_o), 64'd0);
        #1 reset_i = 1'b1;

        // Streaming 1..8 with out_ready high
        out_ready_i = 1'b1;
        drive(1'b1, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_value("stream_alu", 64'(alu_result_o), 64'(i));
            check_value("stream_valid", 64'(out_valid_o), 64'd1);
            check_value("stream_ready", 64'(in_ready_o), 64'd1);
            if (i < 8) drive(1'b1, 32'(i + 1));
            else drive(1'b0, 32'd0);
        end
        tick();
        check_value("stream_drain_valid", 64'(out_valid_o), 64'd0);

        // Stall and skid: A, B, C
        drive(1'b1, 32'h10);
        tick();
        check_value("skid_a_out", 64'(alu_result_o), 64'h10);
        drive(1'b1, 32'h20);
        out_ready_i = 1'b0;
        tick();
        check_value("skid_full_ready", 64'(in_ready_o), 64'd0);
        check_value("skid_hold_a", 64'(alu_result_o), 64'h10);
        drive(1'b1, 32'h30);
        tick();
        check_value("skid_stall_a", 64'(alu_result_o), 64'h10);
        check_value("skid_stall_ready", 64'(in_ready_o), 64'd0);
        check_value("skid_stall_valid", 64'(out_valid_o), 64'd1);
        out_ready_i = 1'b1;
        tick();
        check_value("skid_b_out", 64'(alu_result_o), 64'h20);
        check_value("skid_exit_ready", 64'(in_ready_o), 64'd1);
        tick();
        check_value("skid_c_out", 64'(alu_result_o), 64'h30);
        check_value("skid_c_valid", 64'(out_valid_o), 64'd1);
        drive(1'b0, 32'd0);
        tick();
        check_value("skid_empty", 64'(out_valid_o), 64'd0);

        // Flush while FULL with a write-back transaction offered
        out_ready_i = 1'b0;
        reg_file_write_en_i = 1'b1;
        drive(1'b1, 32'h40);
        tick();
        drive(1'b1, 32'h50);
        tick();
        check_value("flush_pre_ready", 64'(in_ready_o), 64'd0);
        check_value("flush_pre_rfw", 64'(reg_file_write_en_o), 64'd1);
        flush_i = 1'b1;
        drive(1'b1, 32'h60);
        tick();
        check_value("flush_valid", 64'(out_valid_o), 64'd0);
        check_value("flush_rfw", 64'(reg_file_write_en_o), 64'd0);
        check_value("flush_ready", 64'(in_ready_o), 64'd1);
        check_value("flush_alu_held", 64'(alu_result_o), 64'h40);
        flush_i = 1'b0;
        reg_file_write_en_i = 1'b0;
        drive(1'b0, 32'd0);
        tick();
        check_value("flush_no_capture", 64'(out_valid_o), 64'd0);

        // Drain a store from BUSY
        mem_write_en_i = 1'b1; store_data_i = 32'hABC; reg_dest_addr_i = 5'd5;
        drive(1'b1, 32'h77);
        tick();
        check_value("drain_busy_mw", 64'(mem_write_en_o), 64'd1);
        check_value("drain_busy_valid", 64'(out_valid_o), 64'd1);
        mem_write_en_i = 1'b0;
        drive(1'b0, 32'd0);
        out_ready_i = 1'b1;
        tick();
        check_value("drain_valid", 64'(out_valid_o), 64'd0);
        check_value("drain_mw_safe", 64'(mem_write_en_o), 64'd0);
        check_value("drain_alu_held", 64'(alu_result_o), 64'h77);
        check_value("drain_store_held", 64'(store_data_o), 64'hABC);
        check_value("drain_dest_held", 64'(reg_dest_addr_o), 64'd5);
        check_value("drain_ready", 64'(in_ready_o), 64'd1);

        // Simultaneous input and output fire in BUSY
        mem_read_en_i = 1'b1; reg_file_input_ctrl_sig_i = 1'b1;
        drive(1'b1, 32'h81);
        tick();
        check_value("sim_first_alu", 64'(alu_result_o), 64'h81);
        check_value("sim_first_mr", 64'(mem_read_en_o), 64'd1);
        check_value("sim_first_src", 64'(reg_file_input_ctrl_sig_o), 64'd1);
        mem_read_en_i = 1'b0; reg_file_input_ctrl_sig_i = 1'b0;
        drive(1'b1, 32'h82);
        tick();
        check_value("sim_second_alu", 64'(alu_result_o), 64'h82);
        check_value("sim_second_mr", 64'(mem_read_en_o), 64'd0);
        check_value("sim_valid", 64'(out_valid_o), 64'd1);
        check_value("sim_ready", 64'(in_ready_o), 64'd1);
        drive(1'b0, 32'd0);
        tick();
        check_value("sim_empty", 64'(out_valid_o), 64'd0);

        // Asynchronous reset with both entries occupied
        out_ready_i = 1'b0;
        mem_write_en_i = 1'b1;
        drive(1'b1, 32'h91);
        tick();
        drive(1'b1, 32'h92);
        tick();
        check_value("areset_pre_ready", 64'(in_ready_o), 64'd0);
        check_value("areset_pre_mw", 64'(mem_write_en_o), 64'd1);
        drive(1'b0, 32'd0);
        mem_write_en_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        check_value("areset_valid", 64'(out_valid_o), 64'd0);
        check_value("areset_ready", 64'(in_ready_o), 64'd1);
        check_value("areset_mw", 64'(mem_write_en_o), 64'd0);
        check_value("areset_alu", 64'(alu_result_o), 64'd0);
        #1 reset_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        check_value("areset_skid_gone", 64'(out_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
